// File: rtl/batrider_snd_pkg.sv
// Shared definitions for the Batrider 68k-to-Z80 sound-command block.
//   snd_state_e : handshake FSM states
//   A_*         : 68k address field codes (A[2:1]) for the sound window
//   STROBE_LEN  : number of cycles SND_CS is held high per command
package batrider_snd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_STROBE,
        ST_HOLD,
        ST_ACK
    } snd_state_e;

    localparam logic [1:0] A_LATCH  = 2'd0;
    localparam logic [1:0] A_LATCH2 = 2'd1;
    localparam logic [1:0] A_LATCH3 = 2'd2;
    localparam logic [1:0] A_LATCH4 = 2'd3;

    localparam int unsigned STROBE_LEN  = 4;
    localparam logic [1:0]  STROBE_LAST = 2'(STROBE_LEN - 1);

endpackage

// File: rtl/batrider_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low reset, clears all flops
//   d_i    : asynchronous level input
//   rise_o : one-cycle pulse after a synchronised 0->1 transition
module batrider_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/batrider_snd_cmd.sv
// 68k-side sound-command port: latches command bytes for the Z80, strobes
// SND_CS, holds the 68k on DTACK_N until the sound side releases SND_WAIT
// (or a timeout expires), serves reads of the Z80 reply latches and
// latches the Z80-to-68k interrupt.
//   CLK96, RESET96_N        : clock, async active-low reset
//   SEL, A, RNW, LDS_N, DIN : 68k bus access into the sound window
//   DOUT, DTACK_N           : 68k read data and bus acknowledge
//   SOUNDLATCH, SOUNDLATCH2 : command bytes to the Z80
//   SND_CS, SND_WAIT        : command strobe out, sound-side busy in
//   SOUNDLATCH3/4           : Z80 reply bytes
//   SNDIRQ, IRQ_ACK, IRQ_PEND : Z80 interrupt request, ack, latched pending
//   TIMEOUT_ERR             : sticky handshake-timeout flag
module batrider_snd_cmd
    import batrider_snd_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic       CLK96,
    input  logic       RESET96_N,
    input  logic       SEL,
    input  logic [1:0] A,
    input  logic       RNW,
    input  logic       LDS_N,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DTACK_N,
    output logic [7:0] SOUNDLATCH,
    output logic [7:0] SOUNDLATCH2,
    output logic       SND_CS,
    input  logic       SND_WAIT,
    input  logic [7:0] SOUNDLATCH3,
    input  logic [7:0] SOUNDLATCH4,
    input  logic       SNDIRQ,
    output logic       IRQ_PEND,
    input  logic       IRQ_ACK,
    output logic       TIMEOUT_ERR
);

    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    snd_state_e  state_q, state_d;
    logic        acc_q;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  sl_q, sl_d;
    logic [7:0]  sl2_q, sl2_d;
    logic [1:0]  strb_cnt_q, strb_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        terr_q, terr_d;
    logic        irq_q, irq_d;
    logic        irq_rise;
    logic        acc;
    logic        start;

    batrider_edge_sync u_irq_sync (
        .clk_i  (CLK96),
        .rst_ni (RESET96_N),
        .d_i    (SNDIRQ),
        .rise_o (irq_rise)
    );

    assign acc   = SEL & ~LDS_N;
    assign start = acc & ~acc_q;

    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        sl_d       = sl_q;
        sl2_d      = sl2_q;
        strb_cnt_d = strb_cnt_q;
        wait_cnt_d = wait_cnt_q;
        terr_d     = terr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (RNW) begin
                        state_d = ST_ACK;
                        unique case (A)
                            A_LATCH3: dout_d = SOUNDLATCH3;
                            A_LATCH4: dout_d = SOUNDLATCH4;
                            default:  dout_d = 8'hFF;
                        endcase
                    end else begin
                        unique case (A)
                            A_LATCH: begin
                                sl_d    = DIN;
                                state_d = ST_LATCH;
                            end
                            A_LATCH2: begin
                                sl2_d   = DIN;
                                state_d = ST_LATCH;
                            end
                            default: state_d = ST_ACK;
                        endcase
                    end
                end
            end

            ST_LATCH: begin
                strb_cnt_d = '0;
                state_d    = ST_STROBE;
            end

            ST_STROBE: begin
                if (strb_cnt_q == STROBE_LAST) begin
                    // With the sound side already idle the handshake is
                    // complete here, so HOLD is skipped (6-cycle write).
                    if (!SND_WAIT) begin
                        state_d = acc ? ST_ACK : ST_IDLE;
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = ST_HOLD;
                    end
                end else begin
                    strb_cnt_d = strb_cnt_q + 2'd1;
                end
            end

            ST_HOLD: begin
                // A bus cycle abandoned by the 68k finishes without DTACK.
                if (!SND_WAIT) begin
                    state_d = acc ? ST_ACK : ST_IDLE;
                end else if (wait_cnt_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = acc ? ST_ACK : ST_IDLE;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            ST_ACK: begin
                if (!acc) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // A new IRQ edge takes priority over a simultaneous acknowledge.
    always_comb begin
        irq_d = irq_q;
        if (irq_rise) begin
            irq_d = 1'b1;
        end else if (IRQ_ACK) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state_q    <= ST_IDLE;
            // Reset as "access active" so a bus cycle straddling reset
            // release is not mistaken for a new one.
            acc_q      <= 1'b1;
            dout_q     <= 8'hFF;
            sl_q       <= '0;
            sl2_q      <= '0;
            strb_cnt_q <= '0;
            wait_cnt_q <= '0;
            terr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc;
            dout_q     <= dout_d;
            sl_q       <= sl_d;
            sl2_q      <= sl2_d;
            strb_cnt_q <= strb_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            terr_q     <= terr_d;
            irq_q      <= irq_d;
        end
    end

    // Decoded from the state register so reset clears them asynchronously.
    assign SND_CS      = (state_q == ST_STROBE);
    assign DTACK_N     = ~(state_q == ST_ACK);
    assign DOUT        = dout_q;
    assign SOUNDLATCH  = sl_q;
    assign SOUNDLATCH2 = sl2_q;
    assign IRQ_PEND    = irq_q;
    assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_batrider_snd_cmd.sv
// Self-checking bench for batrider_snd_cmd (instantiated with TIMEOUT=16).
module tb_batrider_snd_cmd;

    logic       CLK96 = 1'b0;
    logic       RESET96_N = 1'b1;
    logic       SEL, RNW, LDS_N;
    logic [1:0] A;
    logic [7:0] DIN, DOUT;
    logic       DTACK_N;
    logic [7:0] SOUNDLATCH, SOUNDLATCH2;
    logic       SND_CS, SND_WAIT;
    logic [7:0] SOUNDLATCH3, SOUNDLATCH4;
    logic       SNDIRQ, IRQ_PEND, IRQ_ACK, TIMEOUT_ERR;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK96 = ~CLK96;

    batrider_snd_cmd #(.TIMEOUT(16'd16)) dut (
        .CLK96       (CLK96),
        .RESET96_N   (RESET96_N),
        .SEL         (SEL),
        .A           (A),
        .RNW         (RNW),
        .LDS_N       (LDS_N),
        .DIN         (DIN),
        .DOUT        (DOUT),
        .DTACK_N     (DTACK_N),
        .SOUNDLATCH  (SOUNDLATCH),
        .SOUNDLATCH2 (SOUNDLATCH2),
        .SND_CS      (SND_CS),
        .SND_WAIT    (SND_WAIT),
        .SOUNDLATCH3 (SOUNDLATCH3),
        .SOUNDLATCH4 (SOUNDLATCH4),
        .SNDIRQ      (SNDIRQ),
        .IRQ_PEND    (IRQ_PEND),
        .IRQ_ACK     (IRQ_ACK),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    // drop: 0 = SND_WAIT never raised, -1 = stuck high,
    //       N>0 = raised with SND_CS, seen low at the Nth edge after the rise
    typedef struct {
        logic       rnw;
        logic [1:0] a;
        logic [7:0] din, l3, l4;
        int         drop;
        int         lat;
        int         cs;
        logic [7:0] dout, sl, sl2;
        logic       terr;
    } vec_t;

    typedef struct {
        int         lat;
        int         cs;
        logic [7:0] dout, sl, sl2;
        logic       terr;
        logic       rel;
    } res_t;

    res_t exp_q[$];
    vec_t tbl[11];

    function automatic vec_t mk(input logic rnw, input logic [1:0] a,
                                input logic [7:0] din, input logic [7:0] l3,
                                input logic [7:0] l4, input int drop,
                                input int lat, input int cs,
                                input logic [7:0] dout, input logic [7:0] sl,
                                input logic [7:0] sl2, input logic terr);
        vec_t v;
        v.rnw = rnw; v.a = a; v.din = din; v.l3 = l3; v.l4 = l4;
        v.drop = drop; v.lat = lat; v.cs = cs;
        v.dout = dout; v.sl = sl; v.sl2 = sl2; v.terr = terr;
        return v;
    endfunction

    task automatic cycle();
        @(posedge CLK96);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drives one 68k access, plays the sound side, and scores the result.
    task automatic run_access(input string tag, input vec_t v);
        res_t e, o;
        int   cs_rise;
        e.lat = v.lat; e.cs = v.cs; e.dout = v.dout; e.sl = v.sl;
        e.sl2 = v.sl2; e.terr = v.terr; e.rel = 1'b1;
        exp_q.push_back(e);

        SOUNDLATCH3 = v.l3; SOUNDLATCH4 = v.l4;
        RNW = v.rnw; A = v.a; DIN = v.din; SEL = 1'b1; LDS_N = 1'b0;
        o.lat = 0; o.cs = 0; cs_rise = 0;
        for (int n = 1; n <= 200 && o.lat == 0; n++) begin
            cycle();
            if (SND_CS) begin
                o.cs++;
                if (cs_rise == 0) begin
                    cs_rise = n;
                    if (v.drop != 0) SND_WAIT = 1'b1;
                end
            end
            if (v.drop > 0 && cs_rise != 0 && n == cs_rise + v.drop - 1)
                SND_WAIT = 1'b0;
            if (!DTACK_N) o.lat = n;
        end
        o.dout = DOUT; o.sl = SOUNDLATCH; o.sl2 = SOUNDLATCH2;
        o.terr = TIMEOUT_ERR;
        SEL = 1'b0; LDS_N = 1'b1; SND_WAIT = 1'b0;
        cycle();
        o.rel = DTACK_N;
        cycle();

        e = exp_q.pop_front();
        chk({tag, ".lat"},  o.lat,  e.lat);
        chk({tag, ".cs"},   o.cs,   e.cs);
        chk({tag, ".dout"}, o.dout, e.dout);
        chk({tag, ".sl"},   o.sl,   e.sl);
        chk({tag, ".sl2"},  o.sl2,  e.sl2);
        chk({tag, ".terr"}, o.terr, e.terr);
        chk({tag, ".rel"},  o.rel,  e.rel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   cnt;
        logic seen;

        SEL = 1'b0; LDS_N = 1'b1; RNW = 1'b1; A = 2'd0; DIN = 8'h00;
        SND_WAIT = 1'b0; SOUNDLATCH3 = 8'h00; SOUNDLATCH4 = 8'h00;
        SNDIRQ = 1'b0; IRQ_ACK = 1'b0;

        #1 RESET96_N = 1'b0;
        #2;
        chk("reset.dtack_n",  DTACK_N,     1'b1);
        chk("reset.snd_cs",   SND_CS,      1'b0);
        chk("reset.sl",       SOUNDLATCH,  8'h00);
        chk("reset.sl2",      SOUNDLATCH2, 8'h00);
        chk("reset.dout",     DOUT,        8'hFF);
        chk("reset.irq_pend", IRQ_PEND,    1'b0);
        chk("reset.terr",     TIMEOUT_ERR, 1'b0);
        repeat (3) cycle();
        RESET96_N = 1'b1;
        repeat (2) cycle();

        //               rnw a     din    l3     l4     drop lat cs dout   sl     sl2    terr
        tbl[0]  = mk(1'b0, 2'd0, 8'h5A, 8'h00, 8'h00, 10, 12, 4, 8'hFF, 8'h5A, 8'h00, 1'b0);
        tbl[1]  = mk(1'b1, 2'd3, 8'h00, 8'h00, 8'hC3,  0,  1, 0, 8'hC3, 8'h5A, 8'h00, 1'b0);
        tbl[2]  = mk(1'b1, 2'd2, 8'h00, 8'h3C, 8'hC3,  0,  1, 0, 8'h3C, 8'h5A, 8'h00, 1'b0);
        tbl[3]  = mk(1'b1, 2'd0, 8'h00, 8'h3C, 8'hC3,  0,  1, 0, 8'hFF, 8'h5A, 8'h00, 1'b0);
        tbl[4]  = mk(1'b0, 2'd2, 8'h11, 8'h3C, 8'hC3,  0,  1, 0, 8'hFF, 8'h5A, 8'h00, 1'b0);
        tbl[5]  = mk(1'b0, 2'd1, 8'hA7, 8'h3C, 8'hC3,  0,  6, 4, 8'hFF, 8'h5A, 8'hA7, 1'b0);
        tbl[6]  = mk(1'b1, 2'd1, 8'h00, 8'h12, 8'h34,  0,  1, 0, 8'hFF, 8'h5A, 8'hA7, 1'b0);
        tbl[7]  = mk(1'b0, 2'd0, 8'h0F, 8'h12, 8'h34,  5,  7, 4, 8'hFF, 8'h0F, 8'hA7, 1'b0);
        tbl[8]  = mk(1'b0, 2'd1, 8'h96, 8'h12, 8'h34, -1, 22, 4, 8'hFF, 8'h0F, 8'h96, 1'b1);
        tbl[9]  = mk(1'b0, 2'd3, 8'hE1, 8'h12, 8'h34,  0,  1, 0, 8'hFF, 8'h0F, 8'h96, 1'b1);
        tbl[10] = mk(1'b1, 2'd3, 8'h00, 8'h12, 8'h00,  0,  1, 0, 8'h00, 8'h0F, 8'h96, 1'b1);

        for (int i = 0; i < 11; i++)
            run_access($sformatf("vec%0d", i), tbl[i]);

        // IRQ: set, then a new edge coincident with IRQ_ACK, then ack alone
        SNDIRQ = 1'b1;
        repeat (4) cycle();
        chk("irq.set", IRQ_PEND, 1'b1);
        SNDIRQ = 1'b0;
        repeat (3) cycle();
        chk("irq.hold_after_fall", IRQ_PEND, 1'b1);
        SNDIRQ = 1'b1;
        cycle();
        cycle();
        IRQ_ACK = 1'b1;
        cycle();
        IRQ_ACK = 1'b0;
        chk("irq.set_beats_ack", IRQ_PEND, 1'b1);
        cycle();
        IRQ_ACK = 1'b1;
        cycle();
        IRQ_ACK = 1'b0;
        chk("irq.ack_clears", IRQ_PEND, 1'b0);
        SNDIRQ = 1'b0;
        repeat (3) cycle();

        // 68k abandons the write while the block waits in HOLD
        SND_WAIT = 1'b1;
        RNW = 1'b0; A = 2'd0; DIN = 8'h3C; SEL = 1'b1; LDS_N = 1'b0;
        seen = 1'b0;
        cnt  = 0;
        for (int n = 0; n < 20 && !(seen && !SND_CS); n++) begin
            cycle();
            if (SND_CS) seen = 1'b1;
        end
        chk("abort.hold_reached", seen && !SND_CS, 1'b1);
        SEL = 1'b0; LDS_N = 1'b1;
        repeat (3) cycle();
        SND_WAIT = 1'b0;
        for (int n = 0; n < 6; n++) begin
            cycle();
            if (!DTACK_N) cnt++;
        end
        chk("abort.no_dtack", cnt, 0);
        chk("abort.sl", SOUNDLATCH, 8'h3C);
        run_access("abort.next_read",
                   mk(1'b1, 2'd3, 8'h00, 8'h00, 8'h5D, 0, 1, 0, 8'h5D, 8'h3C, 8'h96, 1'b1));

        // reset pulled during STROBE, access held through release
        SNDIRQ = 1'b1;
        repeat (4) cycle();
        SNDIRQ = 1'b0;
        RNW = 1'b0; A = 2'd0; DIN = 8'h77; SEL = 1'b1; LDS_N = 1'b0;
        for (int n = 0; n < 20 && !SND_CS; n++) cycle();
        chk("rst.strobe_seen", SND_CS, 1'b1);
        cycle();
        #2 RESET96_N = 1'b0;
        #1;
        chk("rst.snd_cs",   SND_CS,      1'b0);
        chk("rst.dtack_n",  DTACK_N,     1'b1);
        chk("rst.sl",       SOUNDLATCH,  8'h00);
        chk("rst.sl2",      SOUNDLATCH2, 8'h00);
        chk("rst.dout",     DOUT,        8'hFF);
        chk("rst.irq_pend", IRQ_PEND,    1'b0);
        chk("rst.terr",     TIMEOUT_ERR, 1'b0);
        repeat (3) cycle();
        RESET96_N = 1'b1;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            cycle();
            if (SND_CS || !DTACK_N) cnt++;
        end
        chk("rst.held_access_ignored", cnt, 0);
        SEL = 1'b0; LDS_N = 1'b1;
        repeat (2) cycle();
        run_access("rst.next_write",
                   mk(1'b0, 2'd0, 8'h4B, 8'h00, 8'h00, 0, 6, 4, 8'hFF, 8'h4B, 8'h00, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
